quad_steer_decoder: RTL and testbench
=====================================

// Module: quad_steer_decoder
// PURPOSE
//  Decodes a 2-phase quadrature steering signal (SteerA/SteerB, as driven into the
//  sprint1 core) back into position, step, direction and rate information.
//  Used as the bench monitor for the joystick-to-quadrature steering path, and as
//  the front end for a real spinner/encoder steering input on the USER port.
//  Everything runs on one clock; the quadrature inputs are asynchronous.
// PARAMETERS
//  FILTER_LEN  4      cycles a synced input must hold stable before it is accepted (1..15)
//  POS_W       8      width of the signed position counter
//  RATE_DIV    22500  rate-window length in clocks (>=2)
// PORTS
//  CLK         in   1      system clock
//  Reset_n     in   1      asynchronous active-low reset
//  clr_i       in   1      sync clear of pos_o, rate window, rate_o, left_o/right_o
//  err_clr_i   in   1      sync clear of err_o
//  quad_a_i    in   1      quadrature phase A (async)
//  quad_b_i    in   1      quadrature phase B (async)
//  pos_o       out  POS_W  signed position, +1 per forward edge (4x decode)
//  step_o      out  1      one-cycle pulse per accepted legal edge
//  dir_o       out  1      direction of last accepted step: 1 = right/forward, 0 = left
//  err_o       out  1      sticky: illegal transition (both phases changed) seen
//  rate_o      out  8      accepted steps in last complete window, saturates at 255
//  right_o     out  1      last complete window had net steps > 0
//  left_o      out  1      last complete window had net steps < 0
// BEHAVIOUR
//  - Reset: all outputs 0. Synchronisers, filters and the window counter go to 0.
//    The prev-state valid flag clears.
//  - Input path per phase: 2-flop synchroniser, then glitch filter. The filtered
//    value takes the synced value after FILTER_LEN consecutive equal samples that
//    differ from it. A shorter pulse is dropped.
//  - The first filtered sample after reset or clr_i loads prev {A,B} and sets valid.
//    It never counts.
//  - Decode cur vs prev {A,B}. The forward sequence is 00->01->11->10->00.
//      . reverse order = backward step
//      . equal = no-op
//      . both bits changed = illegal: err_o <= 1, no step; prev <= cur (resync)
//  - Legal step, registered outputs on the same edge:
//      . step_o = 1 for one cycle
//      . dir_o <= 1 (forward) or 0 (backward)
//      . pos_o += 1 or -1, wrapping mod 2^POS_W (127+1 -> -128 for POS_W=8)
//  - Latency: input edge to step_o high = 2 (sync) + FILTER_LEN + 1 clocks.
//  - Rate window: a down-counter runs from RATE_DIV-1 to 0.
//      . Each window accumulates a step count (saturating 8-bit) and a net count
//        (signed 16-bit, saturating).
//      . On the terminal cycle: rate_o <= step count; right_o/left_o <= sign of net;
//        both accumulators reset. A step arriving in the terminal cycle is counted
//        into the new window.
//  - clr_i has priority over a simultaneous step:
//      . pos_o <= 0 and step_o suppressed
//      . window reloads; rate_o, left_o, right_o <= 0; valid <= 0
//      . err_o and the filters are unaffected
//  - err_clr_i and an illegal transition in the same cycle: err_o stays 1 (set wins).
//  - dir_o holds between steps.
//  - Reset mid-operation returns everything to the reset state immediately. No
//    step is counted for the first post-reset sample.
// STRUCTURE
//  - Package quad_pkg:
//      . typedef logic [1:0] quad_state_t
//      . localparams Q00/Q01/Q11/Q10
//      . function quad_step(prev, cur) returning {illegal, move, fwd}
//      . DIR_FWD = 1'b1
//  - One sub-module: quad_glitch_filter (sync + stability counter), instantiated
//    once per phase with FILTER_LEN.
//  - Top level: decoder, position counter, rate window.
// TESTING
//  1 Reset release, inputs held 00 for 100 clk -> pos_o=0, step_o never high,
//    err_o=0, rate_o=0.
//  2 Forward sequence 00,01,11,10,00, each held 20 clk -> 4 step_o pulses, each
//    2+4+1=7 clk after its edge; pos_o=4; dir_o=1.
//  3 Same sequence reversed -> pos_o=-4 (8'hFC); dir_o=0.
//  4 POS_W=8: 128 forward steps from 0 -> pos_o=-128 (wrap). Then 1 backward step
//    -> 127.
//  5 Illegal and filter cases:
//      . A 3-clk glitch on A -> no step.
//      . 00->11 together -> err_o=1, pos_o unchanged.
//      . err_clr_i pulse -> err_o=0.
//  6 Window and clear, RATE_DIV=100:
//      . 10 forward steps in one window -> at window end rate_o=10, right_o=1,
//        left_o=0.
//      . clr_i in the same cycle as a step -> pos_o=0, no step_o, rate_o=0.

Source files
------------

// File: rtl/quad_steer_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module : quad_pkg
// Quadrature state encoding and the prev->cur transition classifier.
// Rev    : 1.0
// ============================================================================
package quad_pkg;

    typedef logic [1:0] quad_state_t;

    localparam quad_state_t Q00 = 2'b00;
    localparam quad_state_t Q01 = 2'b01;
    localparam quad_state_t Q11 = 2'b11;
    localparam quad_state_t Q10 = 2'b10;

    localparam logic DIR_FWD = 1'b1;

    typedef struct packed {
        logic illegal;
        logic move;
        logic fwd;
    } quad_step_t;

    // Forward order is Q00 -> Q01 -> Q11 -> Q10 -> Q00.
    function automatic quad_step_t quad_step(input quad_state_t prev, input quad_state_t cur);
        quad_step_t r;
        r = '0;
        if ((prev ^ cur) == 2'b11) begin
            r.illegal = 1'b1;
        end else if (prev != cur) begin
            r.move = 1'b1;
            case (prev)
                Q00:     r.fwd = (cur == Q01);
                Q01:     r.fwd = (cur == Q11);
                Q11:     r.fwd = (cur == Q10);
                default: r.fwd = (cur == Q00);
            endcase
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/quad_glitch_filter.sv
`default_nettype none
// ============================================================================
// Module : quad_glitch_filter
// Two-flop synchroniser followed by a stability counter for one phase.
// Rev    : 1.0
// ============================================================================
module quad_glitch_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_filt
);

    localparam logic [3:0] c_CNT_LAST = 4'(FILTER_LEN - 1);

    logic       r_sync0;
    logic       r_sync1;
    logic       r_filt;
    logic [3:0] r_cnt;

    // The filtered value flips only after FILTER_LEN consecutive differing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync0 <= 1'b0;
            r_sync1 <= 1'b0;
            r_filt  <= 1'b0;
            r_cnt   <= 4'd0;
        end else begin
            r_sync0 <= i_async;
            r_sync1 <= r_sync0;
            if (r_sync1 == r_filt) begin
                r_cnt <= 4'd0;
            end else if (r_cnt == c_CNT_LAST) begin
                r_filt <= r_sync1;
                r_cnt  <= 4'd0;
            end else begin
                r_cnt <= r_cnt + 4'd1;
            end
        end
    end

    assign o_filt = r_filt;

endmodule
`default_nettype wire

// File: rtl/quad_steer_decoder.sv
`default_nettype none
// ============================================================================
// Module : quad_steer_decoder
// Quadrature steering decoder: position, step, direction, error and rate.
// Rev    : 1.0
// ============================================================================
module quad_steer_decoder
    import quad_pkg::*;
#(
    parameter int FILTER_LEN = 4,
    parameter int POS_W      = 8,
    parameter int RATE_DIV   = 22500
) (
    input  logic             CLK,
    input  logic             Reset_n,
    input  logic             clr_i,
    input  logic             err_clr_i,
    input  logic             quad_a_i,
    input  logic             quad_b_i,
    output logic [POS_W-1:0] pos_o,
    output logic             step_o,
    output logic             dir_o,
    output logic             err_o,
    output logic [7:0]       rate_o,
    output logic             right_o,
    output logic             left_o
);

    localparam int                c_WIN_W    = $clog2(RATE_DIV);
    localparam logic [c_WIN_W-1:0] c_WIN_LAST = c_WIN_W'(RATE_DIV - 1);
    localparam logic signed [15:0] c_NET_MAX  = 16'sh7FFF;
    localparam logic signed [15:0] c_NET_MIN  = -16'sh8000;

    logic        w_filt_a;
    logic        w_filt_b;
    quad_state_t w_cur;
    quad_state_t r_prev;
    logic        r_valid;
    quad_step_t  w_dec;
    logic        w_step;
    logic        w_illegal;

    logic [c_WIN_W-1:0] r_win_cnt;
    logic [7:0]         r_win_steps;
    logic signed [15:0] r_win_net;
    logic [7:0]         w_steps_nxt;
    logic signed [15:0] w_net_nxt;
    logic               w_term;

    quad_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_a (
        .clk     (CLK),
        .rst_n   (Reset_n),
        .i_async (quad_a_i),
        .o_filt  (w_filt_a)
    );

    quad_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_b (
        .clk     (CLK),
        .rst_n   (Reset_n),
        .i_async (quad_b_i),
        .o_filt  (w_filt_b)
    );

    assign w_cur     = {w_filt_a, w_filt_b};
    assign w_dec     = quad_step(r_prev, w_cur);
    assign w_step    = r_valid & w_dec.move & ~clr_i;
    assign w_illegal = r_valid & w_dec.illegal;
    assign w_term    = (r_win_cnt == '0);

    // prev always follows cur once valid, which also resyncs after an illegal jump.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            r_prev  <= Q00;
            r_valid <= 1'b0;
            pos_o   <= '0;
            step_o  <= 1'b0;
            dir_o   <= 1'b0;
            err_o   <= 1'b0;
        end else begin
            step_o <= 1'b0;
            if (w_illegal) begin
                err_o <= 1'b1;
            end else if (err_clr_i) begin
                err_o <= 1'b0;
            end
            if (clr_i) begin
                pos_o   <= '0;
                r_valid <= 1'b0;
            end else if (!r_valid) begin
                r_prev  <= w_cur;
                r_valid <= 1'b1;
            end else begin
                r_prev <= w_cur;
                if (w_dec.move) begin
                    step_o <= 1'b1;
                    dir_o  <= w_dec.fwd ? DIR_FWD : ~DIR_FWD;
                    pos_o  <= w_dec.fwd ? pos_o + 1'b1 : pos_o - 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_steps_nxt = r_win_steps;
        w_net_nxt   = r_win_net;
        if (w_step) begin
            if (r_win_steps != 8'hFF) begin
                w_steps_nxt = r_win_steps + 8'd1;
            end
            if (w_dec.fwd) begin
                if (r_win_net != c_NET_MAX) begin
                    w_net_nxt = r_win_net + 16'sd1;
                end
            end else if (r_win_net != c_NET_MIN) begin
                w_net_nxt = r_win_net - 16'sd1;
            end
        end
    end

    // A step landing on the terminal cycle seeds the next window.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            r_win_cnt   <= '0;
            r_win_steps <= 8'd0;
            r_win_net   <= 16'sd0;
            rate_o      <= 8'd0;
            right_o     <= 1'b0;
            left_o      <= 1'b0;
        end else if (clr_i) begin
            r_win_cnt   <= c_WIN_LAST;
            r_win_steps <= 8'd0;
            r_win_net   <= 16'sd0;
            rate_o      <= 8'd0;
            right_o     <= 1'b0;
            left_o      <= 1'b0;
        end else if (w_term) begin
            r_win_cnt   <= c_WIN_LAST;
            rate_o      <= r_win_steps;
            right_o     <= (r_win_net > 16'sd0);
            left_o      <= (r_win_net < 16'sd0);
            r_win_steps <= {7'd0, w_step};
            r_win_net   <= w_step ? (w_dec.fwd ? 16'sd1 : -16'sd1) : 16'sd0;
        end else begin
            r_win_cnt   <= r_win_cnt - 1'b1;
            r_win_steps <= w_steps_nxt;
            r_win_net   <= w_net_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_quad_steer_decoder.sv
`default_nettype none
// ============================================================================
// Module : tb_quad_steer_decoder
// Directed and random stimulus against an edge-scheduled reference model.
// Rev    : 1.0
// ============================================================================
module tb_quad_steer_decoder;

    localparam int FL  = 4;
    localparam int PW  = 8;
    localparam int RD  = 100;
    localparam int LAT = 2 + FL + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clr;
    logic          eclr;
    logic          qa;
    logic          qb;
    logic [PW-1:0] pos_o;
    logic          step_o;
    logic          dir_o;
    logic          err_o;
    logic [7:0]    rate_o;
    logic          right_o;
    logic          left_o;

    always #5 clk = ~clk;

    quad_steer_decoder #(.FILTER_LEN(FL), .POS_W(PW), .RATE_DIV(RD)) dut (
        .CLK       (clk),
        .Reset_n   (rst_n),
        .clr_i     (clr),
        .err_clr_i (eclr),
        .quad_a_i  (qa),
        .quad_b_i  (qb),
        .pos_o     (pos_o),
        .step_o    (step_o),
        .dir_o     (dir_o),
        .err_o     (err_o),
        .rate_o    (rate_o),
        .right_o   (right_o),
        .left_o    (left_o)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Predicted events keyed by absolute clock-edge number.
    int sched[int];
    bit errset[int];

    logic [1:0] m_ab;
    logic [7:0] m_pos;
    bit         m_dir, m_err, m_right, m_left, m_step;
    int         m_rate, m_acc, m_net, m_term;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @edge %0d: got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int pos_of(input logic [1:0] ab);
        logic [1:0] ord [4];
        ord = '{2'b00, 2'b01, 2'b11, 2'b10};
        for (int k = 0; k < 4; k++) if (ord[k] == ab) return k;
        return 0;
    endfunction

    function automatic logic [1:0] ab_at(input int k);
        logic [1:0] ord [4];
        ord = '{2'b00, 2'b01, 2'b11, 2'b10};
        return ord[k & 3];
    endfunction

    task automatic model_reset();
        m_pos = 8'd0; m_dir = 0; m_err = 0; m_rate = 0; m_right = 0; m_left = 0;
        m_acc = 0; m_net = 0; m_step = 0;
    endtask

    task automatic model_edge();
        int s;
        m_step = 0;
        if (!rst_n) begin
            model_reset();
            m_term = cyc + 1;
        end else begin
            if (errset.exists(cyc)) m_err = 1;
            else if (eclr) m_err = 0;
            if (clr) begin
                m_pos = 8'd0; m_rate = 0; m_right = 0; m_left = 0;
                m_acc = 0; m_net = 0; m_term = cyc + RD;
            end else begin
                s = sched.exists(cyc) ? sched[cyc] : 0;
                if (cyc == m_term) begin
                    m_rate = m_acc; m_right = (m_net > 0); m_left = (m_net < 0);
                    m_acc = 0; m_net = 0; m_term = cyc + RD;
                end
                if (s != 0) begin
                    m_step = 1;
                    m_acc  = (m_acc < 255) ? m_acc + 1 : 255;
                    m_net  = m_net + s;
                    m_pos  = m_pos + 8'(s);
                    m_dir  = (s > 0);
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        check("step", step_o, m_step);
        check("pos", pos_o, m_pos);
        check("dir", dir_o, m_dir);
        check("err", err_o, m_err);
        check("rate", rate_o, m_rate);
        check("right", right_o, m_right);
        check("left", left_o, m_left);
    endtask

    // Drive a new input level, hold it, optionally pulse clr/err_clr at a given hold offset.
    task automatic apply(input logic [1:0] ab, input int hold, input int clr_off,
                         input int eclr_off, output int first);
        int d;
        d = (pos_of(ab) - pos_of(m_ab)) & 3;
        first = -1;
        if (d == 1) sched[cyc + LAT] = 1;
        else if (d == 3) sched[cyc + LAT] = -1;
        else if (d == 2) errset[cyc + LAT] = 1;
        m_ab = ab;
        {qa, qb} = ab;
        for (int i = 1; i <= hold; i++) begin
            clr  = (i == clr_off);
            eclr = (i == eclr_off);
            tick();
            if (step_o && first < 0) first = i;
        end
        clr  = 1'b0;
        eclr = 1'b0;
    endtask

    task automatic glitch(input int len);
        qa = ~m_ab[1];
        repeat (len) tick();
        qa = m_ab[1];
        repeat (20) tick();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int f, nstep, r, hold;
        rst_n = 1'b0; clr = 1'b0; eclr = 1'b0; qa = 1'b0; qb = 1'b0;
        m_ab = 2'b00;
        model_reset();
        m_term = 1;
        repeat (3) tick();
        rst_n = 1'b1;

        // Idle after reset
        nstep = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (step_o) nstep++;
        end
        check("t1_steps", nstep, 0);
        check("t1_pos", pos_o, 0);
        check("t1_err", err_o, 0);
        check("t1_rate", rate_o, 0);

        // Forward sequence with latency
        for (int k = 1; k <= 4; k++) begin
            apply(ab_at(k), 20, 0, 0, f);
            check("t2_latency", f, LAT);
        end
        check("t2_pos", pos_o, 4);
        check("t2_dir", dir_o, 1);

        // Reverse sequence from a cleared position
        apply(m_ab, 20, 1, 0, f);
        for (int k = 1; k <= 4; k++) apply(ab_at(-k), 20, 0, 0, f);
        check("t3_pos", pos_o, 8'hFC);
        check("t3_dir", dir_o, 0);

        // Position wrap
        apply(m_ab, 20, 1, 0, f);
        for (int k = 0; k < 128; k++) apply(ab_at(pos_of(m_ab) + 1), 8, 0, 0, f);
        check("t4_wrap", pos_o, 8'h80);
        apply(ab_at(pos_of(m_ab) - 1), 20, 0, 0, f);
        check("t4_back", pos_o, 8'h7F);

        // Glitch, illegal jump, error clear
        glitch(3);
        check("t5_glitch_pos", pos_o, 8'h7F);
        apply(ab_at(pos_of(m_ab) + 1), 20, 0, 0, f);
        apply(m_ab ^ 2'b11, 20, 0, 0, f);
        check("t5_illegal_err", err_o, 1);
        check("t5_illegal_pos", pos_o, 8'h80);
        apply(m_ab, 20, 0, 1, f);
        check("t5_errclr", err_o, 0);
        apply(m_ab ^ 2'b11, 20, 0, LAT, f);
        check("t5_set_wins", err_o, 1);
        apply(m_ab, 20, 0, 1, f);

        // Rate window
        apply(m_ab, 20, 1, 0, f);
        for (int k = 0; k < 10; k++) apply(ab_at(pos_of(m_ab) + 1), 8, 0, 0, f);
        repeat (20) tick();
        check("t6_rate", rate_o, 10);
        check("t6_right", right_o, 1);
        check("t6_left", left_o, 0);
        apply(ab_at(pos_of(m_ab) + 1), 20, LAT, 0, f);
        check("t6_clr_nostep", f, -1);
        check("t6_clr_pos", pos_o, 0);
        check("t6_clr_rate", rate_o, 0);

        // Reset mid-operation
        apply(ab_at(pos_of(m_ab) - 1), 20, 0, 0, f);
        {qa, qb} = 2'b00;
        m_ab = 2'b00;
        rst_n = 1'b0;
        #1;
        check("rst_async_pos", pos_o, 0);
        check("rst_async_dir", dir_o, 0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (30) tick();

        // Random traffic
        for (int n = 0; n < 80; n++) begin
            r = $urandom_range(0, 10);
            hold = $urandom_range(8, 25);
            if (r <= 3)       apply(ab_at(pos_of(m_ab) + 1), hold, 0, 0, f);
            else if (r <= 6)  apply(ab_at(pos_of(m_ab) - 1), hold, 0, 0, f);
            else if (r == 7)  apply(m_ab ^ 2'b11, hold, 0, 0, f);
            else if (r == 8)  glitch($urandom_range(1, FL - 1));
            else if (r == 9)  apply(m_ab, hold, 0, $urandom_range(1, hold), f);
            else              apply(m_ab, hold, 1, 0, f);
        end
        repeat (RD + 5) tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
